// File: rtl/mem_pkg.sv
// Shared definitions for the memory responder: RISC-V funct3 encodings,
// FSM states and the access-size decode.
package mem_pkg;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD, SZ_BAD} size_e;

  function automatic size_e size_decode(input logic [2:0] funct3);
    case (funct3[1:0])
      2'b00:   return SZ_BYTE;
      2'b01:   return SZ_HALF;
      2'b10:   return SZ_WORD;
      default: return SZ_BAD;
    endcase
  endfunction

endpackage

// File: rtl/load_extend.sv
// Selects the addressed byte/half/word lane of a 32-bit word and applies
// RISC-V load sign or zero extension.
module load_extend
  import mem_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  lane_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] ext_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word_i[{lane_i, 3'b000} +: 8];
    half_sel = lane_i[1] ? word_i[31:16] : word_i[15:0];
    ext_o    = '0;
    case (size_decode(funct3_i))
      SZ_BYTE: ext_o = funct3_i[2] ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      SZ_HALF: ext_o = funct3_i[2] ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
      SZ_WORD: ext_o = word_i;
      default: ext_o = '0;
    endcase
  end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: valid/ready request in, one-cycle response out after
// WAIT_STATES wait cycles; lane-aware stores and extended loads on a word array.
module mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int CNT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = (WAIT_STATES > 0) ? CNT_W'(WAIT_STATES - 1) : '0;

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              write_q;
  logic [31:0]       addr_q;
  logic [31:0]       wdata_q;
  logic [2:0]        funct3_q;
  logic              rsp_valid_q;
  logic [31:0]       rsp_rdata_q;
  logic              rsp_err_q;

  logic [31:0]       mem_q [DEPTH_WORDS];

  logic              in_idle;
  logic              eff_write;
  logic [31:0]       eff_addr;
  logic [31:0]       eff_wdata;
  logic [2:0]        eff_funct3;
  size_e             size_d;
  logic              err_d;
  logic              access_d;
  logic              we_d;
  logic [3:0]        be_d;
  logic [31:0]       wd_d;
  logic [IDX_W-1:0]  idx_d;
  logic [31:0]       rd_word;
  logic [31:0]       ext_word;
  logic [31:0]       rdata_d;

  // With zero wait states the access happens on the acceptance edge, so the
  // live request inputs are used instead of the not-yet-loaded registers.
  assign in_idle    = (state_q == IDLE);
  assign eff_write  = in_idle ? req_write  : write_q;
  assign eff_addr   = in_idle ? req_addr   : addr_q;
  assign eff_wdata  = in_idle ? req_wdata  : wdata_q;
  assign eff_funct3 = in_idle ? req_funct3 : funct3_q;
  assign idx_d      = eff_addr[IDX_W+1:2];

  always_comb begin
    size_d = size_decode(eff_funct3);
    err_d  = (size_d == SZ_BAD)
          || ((size_d == SZ_HALF) && eff_addr[0])
          || ((size_d == SZ_WORD) && (eff_addr[1:0] != 2'b00))
          || ({2'b00, eff_addr[31:2]} >= 32'(DEPTH_WORDS))
          || (eff_write ? eff_funct3[2] : (eff_funct3 == 3'b110));
    access_d = ((state_q == WAIT) && (cnt_q == '0))
            || (in_idle && req_valid && (WAIT_STATES == 0));
    we_d = access_d && eff_write && !err_d && !reset;
    be_d = 4'b0000;
    wd_d = eff_wdata;
    case (size_d)
      SZ_BYTE: begin
        be_d = 4'b0001 << eff_addr[1:0];
        wd_d = {4{eff_wdata[7:0]}};
      end
      SZ_HALF: begin
        be_d = eff_addr[1] ? 4'b1100 : 4'b0011;
        wd_d = {2{eff_wdata[15:0]}};
      end
      SZ_WORD: be_d = 4'b1111;
      default: be_d = 4'b0000;
    endcase
  end

  assign rd_word = mem_q[idx_d];

  load_extend u_load_extend (
    .word_i   (rd_word),
    .lane_i   (eff_addr[1:0]),
    .funct3_i (eff_funct3),
    .ext_o    (ext_word)
  );

  assign rdata_d = (!eff_write && !err_d) ? ext_word : '0;

  always_ff @(posedge clk) begin
    if (we_d) begin
      for (int b = 0; b < 4; b++) begin
        if (be_d[b]) mem_q[idx_d][8*b +: 8] <= wd_d[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      funct3_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            write_q  <= req_write;
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
            funct3_q <= req_funct3;
            if (WAIT_STATES == 0) begin
              state_q     <= RESP;
              rsp_valid_q <= 1'b1;
              rsp_rdata_q <= rdata_d;
              rsp_err_q   <= err_d;
            end else begin
              state_q <= WAIT;
              cnt_q   <= CNT_LOAD;
            end
          end
        end
        WAIT: begin
          if (cnt_q == '0) begin
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= rdata_d;
            rsp_err_q   <= err_d;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        RESP: begin
          state_q     <= IDLE;
          rsp_rdata_q <= '0;
          rsp_err_q   <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready = in_idle;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: a WAIT_STATES=2 instance for data paths,
// errors and reset abort, plus a WAIT_STATES=0 instance for peak throughput.
module tb_mem_responder;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0, req_write = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [2:0]  req_funct3 = '0;
  logic        req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;

  logic        v0 = 1'b0, w0 = 1'b0;
  logic [31:0] a0 = '0, d0 = '0;
  logic [2:0]  f0 = '0;
  logic        rdy0, rv0, er0;
  logic [31:0] rd0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(2)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_funct3(req_funct3), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err)
  );

  mem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(0)) dut0 (
    .clk(clk), .reset(reset), .req_valid(v0), .req_ready(rdy0),
    .req_write(w0), .req_addr(a0), .req_wdata(d0), .req_funct3(f0),
    .rsp_valid(rv0), .rsp_rdata(rd0), .rsp_err(er0)
  );

  // Issues one request on the WAIT_STATES=2 instance and waits (bounded) for
  // its response; lat = -1 and X data if none arrives.
  task automatic do_req(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [2:0] f3, output logic [31:0] rdata, output logic err,
                        output int lat);
    @(negedge clk);
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata; req_funct3 = f3;
    @(posedge clk);
    lat = -1; rdata = 'x; err = 1'bx;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (rsp_valid) begin
        lat = n; rdata = rsp_rdata; err = rsp_err;
        break;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got %b want 1", req_ready); end
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
    n_cmp++; if (rsp_rdata !== 32'h0) begin n_bad++; $display("FAIL reset_rdata got %h want 0", rsp_rdata); end
    n_cmp++; if (rsp_err !== 1'b0) begin n_bad++; $display("FAIL reset_err got %b want 0", rsp_err); end
    reset = 1'b0;
  endtask

  task automatic test_word();
    logic [31:0] rd; logic er; int lat;
    do_req(1'b1, 32'h10, 32'hDEADBEEF, SW, rd, er, lat);
    n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL sw_latency got %0d want 3", lat); end
    n_cmp++; if (er !== 1'b0 || rd !== 32'h0) begin n_bad++; $display("FAIL sw_rsp got err=%b rdata=%h want 0/0", er, rd); end
    @(negedge clk);
    n_cmp++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin n_bad++; $display("FAIL sw_pulse got valid=%b ready=%b want 0/1", rsp_valid, req_ready); end
    do_req(1'b0, 32'h10, 32'h0, LW, rd, er, lat);
    n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL lw_latency got %0d want 3", lat); end
    n_cmp++; if (rd !== 32'hDEADBEEF || er !== 1'b0) begin n_bad++; $display("FAIL lw_data got %h err=%b want deadbeef/0", rd, er); end
  endtask

  task automatic test_extend();
    logic [31:0] rd; logic er; int lat;
    logic [31:0] exp_v [5] = '{32'h0000007F, 32'hFFFFFFFF, 32'h00000080, 32'hFFFF80FF, 32'h000080FF};
    logic [31:0] addr_v [5] = '{32'h11, 32'h12, 32'h13, 32'h12, 32'h12};
    logic [2:0]  f3_v [5] = '{LB, LB, LBU, LH, LHU};
    do_req(1'b1, 32'h10, 32'h80FF7F01, SW, rd, er, lat);
    for (int i = 0; i < 5; i++) begin
      do_req(1'b0, addr_v[i], 32'h0, f3_v[i], rd, er, lat);
      n_cmp++;
      if (rd !== exp_v[i] || er !== 1'b0)
        begin n_bad++; $display("FAIL extend_%0d got %h err=%b want %h/0", i, rd, er, exp_v[i]); end
    end
  endtask

  task automatic test_partial();
    logic [31:0] rd; logic er; int lat;
    do_req(1'b1, 32'h20, 32'h11223344, SW, rd, er, lat);
    do_req(1'b1, 32'h21, 32'h123456AA, SB, rd, er, lat);
    do_req(1'b0, 32'h20, 32'h0, LW, rd, er, lat);
    n_cmp++; if (rd !== 32'h1122AA44) begin n_bad++; $display("FAIL sb_merge got %h want 1122aa44", rd); end
    do_req(1'b1, 32'h22, 32'hFFFFBEEF, SH, rd, er, lat);
    do_req(1'b0, 32'h20, 32'h0, LW, rd, er, lat);
    n_cmp++; if (rd !== 32'hBEEFAA44) begin n_bad++; $display("FAIL sh_merge got %h want beefaa44", rd); end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic er; int lat;
    do_req(1'b0, 32'h06, 32'h0, LW, rd, er, lat);
    n_cmp++; if (er !== 1'b1 || rd !== 32'h0) begin n_bad++; $display("FAIL lw_misalign got err=%b rdata=%h want 1/0", er, rd); end
    do_req(1'b1, 32'h0, 32'hCAFEF00D, SW, rd, er, lat);
    do_req(1'b1, 32'h1000, 32'h55555555, SW, rd, er, lat);
    n_cmp++; if (er !== 1'b1 || lat !== 3) begin n_bad++; $display("FAIL sw_range got err=%b lat=%0d want 1/3", er, lat); end
    do_req(1'b0, 32'h0, 32'h0, LW, rd, er, lat);
    n_cmp++; if (rd !== 32'hCAFEF00D) begin n_bad++; $display("FAIL sw_range_nowrite got %h want cafef00d", rd); end
    do_req(1'b1, 32'h20, 32'h99999999, 3'b101, rd, er, lat);
    n_cmp++; if (er !== 1'b1) begin n_bad++; $display("FAIL store_f3_101 got err=%b want 1", er); end
    do_req(1'b1, 32'h21, 32'h77777777, SH, rd, er, lat);
    n_cmp++; if (er !== 1'b1) begin n_bad++; $display("FAIL sh_misalign got err=%b want 1", er); end
    do_req(1'b0, 32'h20, 32'h0, LW, rd, er, lat);
    n_cmp++; if (rd !== 32'hBEEFAA44) begin n_bad++; $display("FAIL err_nowrite got %h want beefaa44", rd); end
    do_req(1'b0, 32'h20, 32'h0, 3'b110, rd, er, lat);
    n_cmp++; if (er !== 1'b1 || rd !== 32'h0) begin n_bad++; $display("FAIL load_f3_110 got err=%b rdata=%h want 1/0", er, rd); end
    do_req(1'b0, 32'h20, 32'h0, 3'b011, rd, er, lat);
    n_cmp++; if (er !== 1'b1 || rd !== 32'h0) begin n_bad++; $display("FAIL load_f3_011 got err=%b rdata=%h want 1/0", er, rd); end
  endtask

  // Valid held high: accept every 4th cycle, response 3 cycles later.
  task automatic test_back_to_back();
    int n_rsp = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i == 0) begin
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h10; req_funct3 = LW;
      end
      n_cmp++;
      if (req_ready !== (i % 4 == 0) || rsp_valid !== (i % 4 == 3))
        begin n_bad++; $display("FAIL b2b_cycle%0d got ready=%b valid=%b want %b/%b", i, req_ready, rsp_valid, i % 4 == 0, i % 4 == 3); end
      if (rsp_valid) begin
        n_rsp++;
        n_cmp++; if (rsp_rdata !== 32'h80FF7F01) begin n_bad++; $display("FAIL b2b_data got %h want 80ff7f01", rsp_rdata); end
      end
    end
    @(negedge clk);
    req_valid = 1'b0;
    n_cmp++; if (n_rsp !== 3) begin n_bad++; $display("FAIL b2b_count got %0d want 3", n_rsp); end
  endtask

  // Zero wait states: accept every other cycle, response the next cycle.
  task automatic test_zero_wait();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_cmp++;
      if (rdy0 !== (i % 2 == 0) || rv0 !== (i % 2 == 1))
        begin n_bad++; $display("FAIL ws0_cycle%0d got ready=%b valid=%b want %b/%b", i, rdy0, rv0, i % 2 == 0, i % 2 == 1); end
      if (i % 2 == 1) begin
        n_cmp++;
        if (rd0 !== ((i < 4) ? 32'h0 : 32'h0000ABCD) || er0 !== 1'b0)
          begin n_bad++; $display("FAIL ws0_data%0d got %h err=%b want %h/0", i, rd0, er0, (i < 4) ? 32'h0 : 32'h0000ABCD); end
      end
      v0 = 1'b1; w0 = (i < 4); a0 = 32'h4; d0 = 32'h0000ABCD; f0 = SW;
    end
    @(negedge clk);
    v0 = 1'b0;
  endtask

  task automatic test_reset_mid_store();
    logic [31:0] rd; logic er; int lat;
    int n_rsp = 0;
    do_req(1'b1, 32'h30, 32'hA5A5A5A5, SW, rd, er, lat);
    do_req(1'b0, 32'h30, 32'h0, LW, rd, er, lat);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h30; req_wdata = 32'h12345678; req_funct3 = SW;
    @(negedge clk);
    req_valid = 1'b0;
    n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL mid_in_wait got ready=%b want 0", req_ready); end
    reset = 1'b1;
    #1;
    n_cmp++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0)
      begin n_bad++; $display("FAIL mid_reset_outputs got ready=%b valid=%b rdata=%h err=%b want 1/0/0/0", req_ready, rsp_valid, rsp_rdata, rsp_err); end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (rsp_valid) n_rsp++;
    end
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (rsp_valid) n_rsp++;
    end
    n_cmp++; if (n_rsp !== 0) begin n_bad++; $display("FAIL mid_no_rsp got %0d responses want 0", n_rsp); end
    do_req(1'b0, 32'h30, 32'h0, LW, rd, er, lat);
    n_cmp++; if (rd !== 32'hA5A5A5A5) begin n_bad++; $display("FAIL mid_store_lost got %h want a5a5a5a5", rd); end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    test_reset();
    test_word();
    test_extend();
    test_partial();
    test_errors();
    test_back_to_back();
    test_zero_wait();
    test_reset_mid_store();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the multicycle RISC-V core. It accepts fetch, load and store requests issued by the core's control path over a valid/ready handshake. It applies RISC-V byte/half/word lane selection and load sign/zero extension, and returns a one-cycle response after a programmable number of wait states. It sits between the core datapath and the word-organised storage array, and replaces the zero-latency combinational memory.

## Interface
Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words in the storage array; byte address range is 0 to 4*DEPTH_WORDS-1.
- WAIT_STATES, 2: cycles spent in WAIT before the response; 0 is legal.

Ports:
- clk  in  1  single clock, all state on rising edge.
- reset  in  1  asynchronous, active-high; clears all state except the storage array.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept; high only in IDLE.
- req_write  in  1  1 = store, 0 = load/fetch.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; the relevant bytes are in the low bits.
- req_funct3  in  3  access size/sign; fetches use 010.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- rsp_err  out  1  valid with rsp_valid; set for a misaligned or out-of-range access.

## Operation
- States: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, capture addr/wdata/funct3/write into request registers.
  - Go to WAIT, loading the counter with WAIT_STATES-1; if WAIT_STATES=0, go directly to RESP.
- WAIT:
  - Decrement the counter.
  - At 0, go to RESP and perform the array access.
  - Loads read the word; stores write the enabled lanes.
- RESP:
  - rsp_valid=1 for exactly one cycle, then return to IDLE.
  - Request inputs are ignored in RESP.
- Word index is addr[31:2]. Lane is addr[1:0].
- Sizes:
  - funct3[1:0]=00 is byte.
  - 01 is half; half requires addr[0]=0.
  - 10 is word; word requires addr[1:0]=00.
  - funct3[1:0]=11 is illegal and sets rsp_err.
- Loads:
  - funct3[2]=0 sign-extends.
  - funct3[2]=1 zero-extends.
  - funct3=110 is illegal and sets rsp_err.
- Stores:
  - Byte store writes req_wdata[7:0] into lane addr[1:0].
  - Half store writes req_wdata[15:0] into lanes {addr[1],0} and {addr[1],1}.
  - funct3[2]=1 on a store sets rsp_err.
- Errors (misaligned, addr ≥ 4*DEPTH_WORDS, or illegal funct3):
  - No array write.
  - rsp_rdata=0, rsp_err=1.
- Reset values: state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, counter 0.
- The array is not cleared by reset.

## Timing
- Acceptance edge: the rising edge with req_valid & req_ready.
- rsp_valid is high in cycle WAIT_STATES+1 after acceptance; WAIT_STATES=0 gives 1-cycle latency.
- rsp_rdata/rsp_err are registered and stable for the whole rsp_valid cycle.
- The store commits on the edge entering RESP.
- A load issued immediately after a store to the same word returns the new data.
- Back-to-back: the next request can be accepted in the cycle after RESP; peak throughput is one request per WAIT_STATES+2 cycles.
- Reset asserted mid-transaction:
  - Aborts immediately and returns to IDLE.
  - A store not yet committed (still in WAIT) is lost.
  - No rsp_valid is produced for the aborted request.

## Structure
- Package mem_pkg holds:
  - funct3 constants LB/LH/LW/LBU/LHU and SB/SH/SW.
  - The state enum {IDLE, WAIT, RESP}.
  - The size decode helper function.
- Sub-module load_extend: combinational; takes word, lane, funct3 and produces the 32-bit extended value. It is shared with any future cache fill path.
- Counter width is $clog2(WAIT_STATES+1), minimum 1.

## Test plan
- Word store and load, WAIT_STATES=2:
  - Store addr 0x10, data 0xDEADBEEF, funct3 010: rsp_valid at cycle 3, rsp_err=0.
  - Load the same address: rsp_rdata=0xDEADBEEF at cycle 3.
- Byte and half extension:
  - Word 0x10 holds 0x80FF7F01.
  - LB 0x11 -> 0x0000007F.
  - LB 0x12 -> 0xFFFFFFFF.
  - LBU 0x13 -> 0x00000080.
  - LH 0x12 -> 0xFFFF80FF.
  - LHU 0x12 -> 0x000080FF.
- Partial stores:
  - SB 0xAA to 0x21 over 0x11223344 -> word reads 0x1122AA44.
  - SH 0xBEEF to 0x22 -> word reads 0xBEEFAA44.
- Errors:
  - LW 0x06 -> rsp_err=1, rsp_rdata=0.
  - SW to 4*DEPTH_WORDS -> rsp_err=1 and no array change.
  - LHU-type store funct3 101 -> rsp_err=1.
- Handshake:
  - req_valid held high continuously: req_ready is low in WAIT/RESP, and exactly one response per accepted request.
  - With WAIT_STATES=0, one response every 2 cycles.
- Reset mid-store:
  - Assert reset in the WAIT cycle of SW 0x30 = 0x12345678: no rsp_valid, all outputs go to reset values, and a later LW 0x30 returns the old contents.
